// File: rtl/lanes_pkg.sv
// Shared types and constants for the lane frame multiplexer.
// Imported by lanes_rr_arbiter and lanes_frame_mux.
package lanes_pkg;

    localparam int LANES_MAX = 16;
    localparam int IDX_W = 4;
    localparam logic [7:0] LANE_TERM_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        ABORT,
        DRAIN
    } state_e;

endpackage

// File: rtl/lanes_rr_arbiter.sv
// Combinational round-robin search over masked lane requests,
// starting one past the pointer and wrapping at LANES.
module lanes_rr_arbiter
    import lanes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0] req,
    input  logic [LANES-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [LANES-1:0] act;
    int               cand;

    always_comb begin
        act       = req & mask;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int k = 0; k < LANES; k++) begin
            cand = int'(ptr) + k + 1;
            if (cand >= LANES) begin
                cand = cand - LANES;
            end
            if (!gnt_valid && |(act & (LANES'(1) << cand))) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/lanes_frame_mux.sv
// Merges per-lane byte frames onto one registered stream with a stall timeout.
// Define LANES_FRAME_MUX_STATS_EN to build the per-lane frame counters.
module lanes_frame_mux
    import lanes_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int TO_WIDTH = 16
) (
    input  logic                  clk_core,
    input  logic                  clk_core_resn,
    input  logic [LANES*8-1:0]    s_axis_tdata,
    input  logic [LANES*8-1:0]    s_axis_tdest,
    input  logic [LANES-1:0]      s_axis_tlast,
    input  logic [LANES-1:0]      s_axis_tvalid,
    output logic [LANES-1:0]      s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic [7:0]            m_axis_tdest,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [LANES-1:0]      cfg_lane_enable,
    input  logic [TO_WIDTH-1:0]   cfg_frame_timeout,
    output logic [3:0]            status_grant_lane,
    output logic                  status_busy,
    output logic                  stat_timeout,
    output logic [LANES*16-1:0]   stat_frames
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TO_WIDTH-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]           frame_dest_q, frame_dest_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic [7:0]           m_data_q, m_data_d;
    logic [7:0]           m_dest_q, m_dest_d;
    logic                 stat_to_q, stat_to_d;

    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic [LANES-1:0]     g_onehot;
    logic [LANES*8-1:0]   data_sh;
    logic [LANES*8-1:0]   dest_sh;
    logic [LANES*8-1:0]   arb_dest_sh;
    logic                 g_valid;
    logic                 g_last;
    logic [7:0]           g_data;
    logic [7:0]           g_dest;
    logic [7:0]           arb_dest;
    logic                 out_free;
    logic                 lane_rdy;

    lanes_rr_arbiter #(
        .LANES(LANES)
    ) u_arb (
        .req      (s_axis_tvalid),
        .mask     (cfg_lane_enable),
        .ptr      (ptr_q),
        .gnt_idx  (arb_idx),
        .gnt_valid(arb_valid)
    );

    // Select the granted lane with shifts so any LANES value stays width-clean
    assign g_onehot    = LANES'(1) << grant_q;
    assign data_sh     = s_axis_tdata >> {grant_q, 3'b000};
    assign dest_sh     = s_axis_tdest >> {grant_q, 3'b000};
    assign arb_dest_sh = s_axis_tdest >> {arb_idx, 3'b000};
    assign g_valid     = |(s_axis_tvalid & g_onehot);
    assign g_last      = |(s_axis_tlast & g_onehot);
    assign g_data      = data_sh[7:0];
    assign g_dest      = dest_sh[7:0];
    assign arb_dest    = arb_dest_sh[7:0];
    assign out_free    = !m_valid_q || m_axis_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        to_cnt_d     = to_cnt_q;
        frame_dest_d = frame_dest_q;
        m_valid_d    = m_valid_q && !m_axis_tready;
        m_data_d     = m_data_q;
        m_dest_d     = m_dest_q;
        m_last_d     = m_last_q;
        stat_to_d    = 1'b0;
        lane_rdy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d      = arb_idx;
                    ptr_d        = arb_idx;
                    frame_dest_d = arb_dest;
                    to_cnt_d     = '0;
                    state_d      = PASS;
                end
            end
            PASS: begin
                lane_rdy = out_free;
                if (g_valid && out_free) begin
                    m_valid_d    = 1'b1;
                    m_data_d     = g_data;
                    m_dest_d     = g_dest;
                    m_last_d     = g_last;
                    frame_dest_d = g_dest;
                    to_cnt_d     = '0;
                    if (g_last) begin
                        state_d = IDLE;
                    end
                end else if (g_valid) begin
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                    if (cfg_frame_timeout != '0 &&
                        to_cnt_d == cfg_frame_timeout) begin
                        state_d = ABORT;
                    end
                end
            end
            ABORT: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = LANE_TERM_BYTE;
                    m_dest_d  = frame_dest_q;
                    m_last_d  = 1'b1;
                    stat_to_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                // Swallow the rest of the aborted frame
                lane_rdy = 1'b1;
                if (g_valid && g_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= IDX_W'(LANES - 1);
            to_cnt_q     <= '0;
            frame_dest_q <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_dest_q     <= '0;
            m_last_q     <= 1'b0;
            stat_to_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            to_cnt_q     <= to_cnt_d;
            frame_dest_q <= frame_dest_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_dest_q     <= m_dest_d;
            m_last_q     <= m_last_d;
            stat_to_q    <= stat_to_d;
        end
    end

`ifdef LANES_FRAME_MUX_STATS_EN
    logic                 frame_done;
    logic [LANES*16-1:0]  frames_q, frames_d;

    assign frame_done = (state_q == PASS && g_valid && out_free && g_last) ||
                        (state_q == ABORT && out_free);

    always_comb begin
        frames_d = frames_q;
        if (frame_done) begin
            for (int i = 0; i < LANES; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    frames_d[16*i +: 16] = frames_q[16*i +: 16] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            frames_q <= '0;
        end else begin
            frames_q <= frames_d;
        end
    end

    assign stat_frames = frames_q;
`else
    assign stat_frames = '0;
`endif

    assign s_axis_tready     = g_onehot & {LANES{lane_rdy}};
    assign m_axis_tdata      = m_data_q;
    assign m_axis_tdest      = m_dest_q;
    assign m_axis_tlast      = m_last_q;
    assign m_axis_tvalid     = m_valid_q;
    assign status_grant_lane = grant_q;
    assign status_busy       = (state_q != IDLE);
    assign stat_timeout      = stat_to_q;

endmodule
